lcd_char_ctrl: RTL
==================

Name: lcd_char_ctrl

Overview:
Parametrised HD44780-style character LCD controller, successor to lcd_control. Runs a timed power-on init sequence, then accepts command/data bytes over a valid/ready request port and drives the shared sf_d LCD bus in 4-bit or 8-bit mode. All timing is set by cycle-count parameters rather than a fixed clock. Sits between the display-content sequencer and the board LCD pins; sf_ceo parks the shared StrataFlash off the bus.

Parameters:
BUS_W, 4, LCD data bus width; 4 or 8 only (elaboration error otherwise)
PWRUP_CYC, 750000, power-up wait before first init write (15 ms @ 50 MHz)
INIT1_CYC, 205000, wait after first 0x3 wake-up write (4.1 ms)
INIT2_CYC, 5000, wait after second wake-up write (100 us)
EXEC_CYC, 2000, post-byte wait for normal commands and data (40 us)
CLEAR_CYC, 82000, post-byte wait for clear/home commands 0x01-0x03 (1.64 ms)
E_SETUP_CYC, 2, rs/data setup before lcd_e rises (>=1)
E_PULSE_CYC, 12, lcd_e high time (>=1)
E_HOLD_CYC, 1, data hold after lcd_e falls (>=1)
NIB_GAP_CYC, 50, gap between upper and lower nibble in 4-bit mode (1 us)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init_done  in  1  board boot complete; init sequence cannot start until it is seen high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_rs  in  1  0 = command, 1 = data
req_data  in  8  byte to write
init_ok  out  1  init sequence finished; sticky until reset
sf_d  out  BUS_W  LCD data bus (upper data lines)
sf_ceo  out  1  StrataFlash chip-enable, held 1
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write, held 0 (write only)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: sf_d=0, lcd_e=0, lcd_rs=0, lcd_rw=0, sf_ceo=1, req_ready=0, init_ok=0; FSM in S_BOOT.
- All outputs are registered. Reset asserted mid-transfer: lcd_e=0 at the next edge, request is dropped, init restarts from S_BOOT.
- FSM: S_BOOT -> S_PWRUP -> S_INIT -> S_IDLE -> S_XFER -> S_EXEC -> S_IDLE.
- S_BOOT: waits for init_done=1, then moves to S_PWRUP. init_done is sampled once; later deassertion is ignored.
- S_PWRUP: counts PWRUP_CYC cycles.
- S_INIT walks a fixed step ROM, each step = one bus write plus its wait:
  - BUS_W=4: nibbles 0x3 (INIT1_CYC), 0x3 (INIT2_CYC), 0x3 (EXEC_CYC), 0x2 (EXEC_CYC); then full bytes 0x28, 0x06, 0x0C (EXEC_CYC each) and 0x01 (CLEAR_CYC).
  - BUS_W=8: words 0x30, 0x30, 0x30 (INIT1/INIT2/EXEC), then 0x38, 0x06, 0x0C, 0x01.
  - lcd_rs=0 throughout. init_ok rises on the cycle S_IDLE is entered.
- Bus write (strobe): drive sf_d/lcd_rs; hold E_SETUP_CYC cycles; lcd_e=1 for E_PULSE_CYC cycles; lcd_e=0 and data held E_HOLD_CYC cycles.
- 4-bit byte: upper nibble on sf_d, strobe, NIB_GAP_CYC idle cycles, lower nibble, strobe.
- 8-bit byte: single strobe.
- Handshake: req_ready=1 only in S_IDLE. Transfer occurs when req_valid and req_ready are both 1; the request is latched and req_ready drops the following cycle. req_data/req_rs may change after acceptance.
- Post-byte wait (S_EXEC): CLEAR_CYC if req_rs=0 and req_data in {0x01,0x02,0x03}; otherwise EXEC_CYC. Then return to S_IDLE and assert req_ready.
- Requests before init_ok are not accepted (req_ready=0); req_valid may stay high and is taken in the first S_IDLE cycle.
- Back-to-back: the minimum request spacing is one full strobe plus the exec wait plus 1 idle cycle.
- Timer: single down-counter sized clog2 of the largest *_CYC parameter; loaded value N yields exactly N cycles.

Decomposition:
- Package lcd_char_pkg: FSM state enumeration; init step ROM constants for both bus widths (value, wait-select); the clear/home command codes.
- One sub-module, lcd_bus_strobe: takes a start pulse plus word/rs, runs the setup/pulse/hold timing, and returns a done pulse. The parent owns init sequencing, nibble split, exec waits and the handshake.

Test Plan:
1. Hold init_done=0 for 1000 cycles after reset -> lcd_e never rises; req_ready=0, init_ok=0, sf_ceo=1, lcd_rw=0.
2. BUS_W=4, small params (PWRUP=100, INIT1=40, INIT2=20, EXEC=10, CLEAR=30); raise init_done -> exactly 12 lcd_e pulses with sf_d 3,3,3,2,2,8,0,6,0,C,0,1 at rs=0; init_ok=1 CLEAR_CYC cycles after the last pulse ends.
3. After init, send req_rs=1, req_data=0x41 -> two pulses, sf_d=4 then 1, lcd_rs=1, NIB_GAP between them; req_ready low until EXEC_CYC after the second strobe.
4. Send command 0x01, then 0x80 held valid -> req_ready stays low CLEAR_CYC cycles after the 0x01 strobe; 0x80 is accepted in the first ready cycle and waits EXEC_CYC.
5. BUS_W=8 build -> 7 init pulses with sf_d 0x30,0x30,0x30,0x38,0x06,0x0C,0x01; data 0x5A produces a single pulse with sf_d=0x5A.
6. Assert reset for 1 cycle during lcd_e high of a data write -> lcd_e=0 next cycle, req_ready=0, init_ok=0; the full init sequence reruns once init_done is seen.

Source files
------------

// File: rtl/lcd_char_pkg.sv
// ----------------------------------------------------------------
// lcd_char_pkg : shared types, init step ROM and command codes
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package lcd_char_pkg;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_PWRUP = 3'd1,
    S_INIT  = 3'd2,
    S_IDLE  = 3'd3,
    S_XFER  = 3'd4,
    S_EXEC  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_ST1  = 2'd0,
    PH_GAP  = 2'd1,
    PH_ST2  = 2'd2,
    PH_WAIT = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } strobe_e;

  typedef enum logic [1:0] {
    W_INIT1 = 2'd0,
    W_INIT2 = 2'd1,
    W_EXEC  = 2'd2,
    W_CLEAR = 2'd3
  } wsel_e;

  typedef struct packed {
    logic [7:0] val;
    logic       one_strobe;
    wsel_e      wsel;
  } init_step_t;

  localparam logic [2:0] c_last_step4 = 3'd7;
  localparam logic [2:0] c_last_step8 = 3'd6;

  localparam logic [7:0] c_cmd_clear    = 8'h01;
  localparam logic [7:0] c_cmd_home     = 8'h02;
  localparam logic [7:0] c_cmd_home_alt = 8'h03;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 4-bit mode: the first four steps are single wake-up nibbles (low nibble of val)
  function automatic init_step_t init_step(input int bus_w, input logic [2:0] idx);
    init_step_t s;
    s = '{val: 8'h00, one_strobe: 1'b1, wsel: W_EXEC};
    if (bus_w == 8) begin
      case (idx)
        3'd0:    s = '{8'h30, 1'b1, W_INIT1};
        3'd1:    s = '{8'h30, 1'b1, W_INIT2};
        3'd2:    s = '{8'h30, 1'b1, W_EXEC};
        3'd3:    s = '{8'h38, 1'b1, W_EXEC};
        3'd4:    s = '{8'h06, 1'b1, W_EXEC};
        3'd5:    s = '{8'h0C, 1'b1, W_EXEC};
        default: s = '{8'h01, 1'b1, W_CLEAR};
      endcase
    end else begin
      case (idx)
        3'd0:    s = '{8'h03, 1'b1, W_INIT1};
        3'd1:    s = '{8'h03, 1'b1, W_INIT2};
        3'd2:    s = '{8'h03, 1'b1, W_EXEC};
        3'd3:    s = '{8'h02, 1'b1, W_EXEC};
        3'd4:    s = '{8'h28, 1'b0, W_EXEC};
        3'd5:    s = '{8'h06, 1'b0, W_EXEC};
        3'd6:    s = '{8'h0C, 1'b0, W_EXEC};
        default: s = '{8'h01, 1'b0, W_CLEAR};
      endcase
    end
    return s;
  endfunction

  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == c_cmd_clear || data == c_cmd_home || data == c_cmd_home_alt);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_char_ctrl_strobe.sv
// ----------------------------------------------------------------
// lcd_bus_strobe : one LCD bus write with setup / enable / hold timing
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module lcd_bus_strobe
  import lcd_char_pkg::*;
#(
  parameter int BUS_W       = 4,
  parameter int E_SETUP_CYC = 2,
  parameter int E_PULSE_CYC = 12,
  parameter int E_HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BUS_W-1:0] word_i,
  input  logic             rs_i,
  output logic [BUS_W-1:0] sf_d_o,
  output logic             lcd_e_o,
  output logic             lcd_rs_o,
  output logic             done_o
);

  localparam int c_cnt_w = $clog2(max_int(max_int(E_SETUP_CYC, E_PULSE_CYC), E_HOLD_CYC) + 1);

  strobe_e            state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic               e_q, e_d;
  logic               rs_q, rs_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    e_d     = e_q;
    rs_d    = rs_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          data_d  = word_i;
          rs_d    = rs_i;
          cnt_d   = c_cnt_w'(E_SETUP_CYC - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = c_cnt_w'(E_PULSE_CYC - 1);
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = c_cnt_w'(E_HOLD_CYC - 1);
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign sf_d_o   = data_q;
  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign done_o   = done_q;

endmodule

`default_nettype wire

// File: rtl/lcd_char_ctrl.sv
// ----------------------------------------------------------------
// lcd_char_ctrl : HD44780 character LCD controller (power-on init + byte writes)
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module lcd_char_ctrl
  import lcd_char_pkg::*;
#(
  parameter int BUS_W       = 4,
  parameter int PWRUP_CYC   = 750000,
  parameter int INIT1_CYC   = 205000,
  parameter int INIT2_CYC   = 5000,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int E_SETUP_CYC = 2,
  parameter int E_PULSE_CYC = 12,
  parameter int E_HOLD_CYC  = 1,
  parameter int NIB_GAP_CYC = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rs,
  input  logic [7:0]       req_data,
  output logic             init_ok,
  output logic [BUS_W-1:0] sf_d,
  output logic             sf_ceo,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw
);

  localparam int c_max_cyc = max_int(max_int(max_int(PWRUP_CYC, INIT1_CYC), max_int(INIT2_CYC, EXEC_CYC)),
                                     max_int(CLEAR_CYC, NIB_GAP_CYC));
  localparam int c_tmr_w = $clog2(c_max_cyc + 1);

  localparam logic [c_tmr_w-1:0] c_pwrup = c_tmr_w'(PWRUP_CYC);
  localparam logic [c_tmr_w-1:0] c_init1 = c_tmr_w'(INIT1_CYC);
  localparam logic [c_tmr_w-1:0] c_init2 = c_tmr_w'(INIT2_CYC);
  localparam logic [c_tmr_w-1:0] c_exec  = c_tmr_w'(EXEC_CYC);
  localparam logic [c_tmr_w-1:0] c_clear = c_tmr_w'(CLEAR_CYC);
  localparam logic [c_tmr_w-1:0] c_gap   = c_tmr_w'(NIB_GAP_CYC);
  localparam logic [2:0]         c_last_step = (BUS_W == 8) ? c_last_step8 : c_last_step4;

  function automatic logic [c_tmr_w-1:0] wait_cyc(input wsel_e w);
    case (w)
      W_INIT1: return c_init1;
      W_INIT2: return c_init2;
      W_CLEAR: return c_clear;
      default: return c_exec;
    endcase
  endfunction

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [2:0]         step_q, step_d;
  logic [c_tmr_w-1:0] tmr_q, tmr_d;
  logic [7:0]         wbyte_q, wbyte_d;
  logic               one_q, one_d;
  logic               wrs_q, wrs_d;
  logic               clear_q, clear_d;
  logic               start_q, start_d;
  logic               ready_q, ready_d;
  logic               init_ok_q, init_ok_d;
  logic               ceo_q, rw_q;

  logic [BUS_W-1:0]   w_word;
  logic               w_strb_done;
  logic               w_tmr_end;
  logic [2:0]         w_rom_idx;
  init_step_t         w_rom;

  // A timer loaded with N expires on its N-th cycle (value 1)
  assign w_tmr_end = (tmr_q <= c_tmr_w'(1));
  assign w_rom_idx = (state_q == S_PWRUP) ? 3'd0 :
                     (phase_q == PH_WAIT) ? step_q + 3'd1 : step_q;
  assign w_rom     = init_step(BUS_W, w_rom_idx);

  generate
    if (BUS_W == 8) begin : g_bus8
      assign w_word = wbyte_q;
    end else if (BUS_W == 4) begin : g_bus4
      assign w_word = (one_q || phase_q == PH_ST2) ? wbyte_q[3:0] : wbyte_q[7:4];
    end else begin : g_bad_bus
      $error("lcd_char_ctrl: BUS_W must be 4 or 8");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_BOOT;
      phase_q   <= PH_ST1;
      step_q    <= '0;
      tmr_q     <= '0;
      wbyte_q   <= '0;
      one_q     <= 1'b1;
      wrs_q     <= 1'b0;
      clear_q   <= 1'b0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      init_ok_q <= 1'b0;
      ceo_q     <= 1'b1;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      tmr_q     <= tmr_d;
      wbyte_q   <= wbyte_d;
      one_q     <= one_d;
      wrs_q     <= wrs_d;
      clear_q   <= clear_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      init_ok_q <= init_ok_d;
      ceo_q     <= 1'b1;
      rw_q      <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    tmr_d   = tmr_q;
    wbyte_d = wbyte_q;
    one_d   = one_q;
    wrs_d   = wrs_q;
    clear_d = clear_q;
    start_d = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (init_done) begin
          state_d = S_PWRUP;
          tmr_d   = c_pwrup;
        end
      end
      S_PWRUP: begin
        if (w_tmr_end) begin
          state_d = S_INIT;
          phase_d = PH_ST1;
          step_d  = 3'd0;
          start_d = 1'b1;
          wbyte_d = w_rom.val;
          one_d   = w_rom.one_strobe;
          wrs_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_INIT, S_XFER: begin
        case (phase_q)
          PH_GAP: begin
            if (w_tmr_end) begin
              phase_d = PH_ST2;
              start_d = 1'b1;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          PH_WAIT: begin
            if (w_tmr_end) begin
              if (step_q == c_last_step) begin
                state_d = S_IDLE;
              end else begin
                step_d  = step_q + 3'd1;
                phase_d = PH_ST1;
                start_d = 1'b1;
                wbyte_d = w_rom.val;
                one_d   = w_rom.one_strobe;
              end
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          default: begin
            if (w_strb_done) begin
              if (phase_q == PH_ST1 && !one_q) begin
                phase_d = PH_GAP;
                tmr_d   = c_gap;
              end else if (state_q == S_INIT) begin
                phase_d = PH_WAIT;
                tmr_d   = wait_cyc(w_rom.wsel);
              end else begin
                state_d = S_EXEC;
                tmr_d   = clear_q ? c_clear : c_exec;
              end
            end
          end
        endcase
      end
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_XFER;
          phase_d = PH_ST1;
          start_d = 1'b1;
          wbyte_d = req_data;
          wrs_d   = req_rs;
          one_d   = (BUS_W == 8);
          clear_d = is_clear_cmd(req_rs, req_data);
        end
      end
      S_EXEC: begin
        if (w_tmr_end) state_d = S_IDLE;
        else           tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = S_BOOT;
    endcase
    ready_d   = (state_d == S_IDLE);
    init_ok_d = init_ok_q | (state_d == S_IDLE);
  end

  lcd_bus_strobe #(
    .BUS_W      (BUS_W),
    .E_SETUP_CYC(E_SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC),
    .E_HOLD_CYC (E_HOLD_CYC)
  ) u_strobe (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_q),
    .word_i  (w_word),
    .rs_i    (wrs_q),
    .sf_d_o  (sf_d),
    .lcd_e_o (lcd_e),
    .lcd_rs_o(lcd_rs),
    .done_o  (w_strb_done)
  );

  assign req_ready = ready_q;
  assign init_ok   = init_ok_q;
  assign sf_ceo    = ceo_q;
  assign lcd_rw    = rw_q;

endmodule

`default_nettype wire
